// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle sequencer for the PWM compare stage: ramps duty toward a target one step per RATE period boundaries.
// Optional soft start from duty 0 after reset: define PWM_SEQ_SOFTSTART_EN.
module pwm_duty_sequencer #(
  parameter int unsigned STEPS        = 10,
  parameter int unsigned DUTY_W       = 4,
  parameter int unsigned DEFAULT_DUTY = 5,
  parameter int unsigned RATE         = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_end,
  input  logic              req_valid,
  input  logic [DUTY_W-1:0] req_duty,
  output logic              req_ready,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              err_clr,
  output logic [DUTY_W-1:0] duty_out,
  output logic [DUTY_W-1:0] target,
  output logic              busy,
  output logic              err_range
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  localparam int unsigned       RATE_W      = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [DUTY_W-1:0] MAX_DUTY    = DUTY_W'(STEPS);
  localparam logic [DUTY_W-1:0] INIT_TARGET = DUTY_W'(DEFAULT_DUTY);
  localparam logic [RATE_W-1:0] RATE_LAST   = RATE_W'(RATE - 1);

`ifdef PWM_SEQ_SOFTSTART_EN
  localparam logic [DUTY_W-1:0] INIT_DUTY  = '0;
  localparam state_t            INIT_STATE = (DEFAULT_DUTY == 0) ? IDLE : RAMP;
`else
  localparam logic [DUTY_W-1:0] INIT_DUTY  = INIT_TARGET;
  localparam state_t            INIT_STATE = IDLE;
`endif

  state_t            state, state_d;
  logic [DUTY_W-1:0] duty_d, target_d;
  logic [RATE_W-1:0] rate_cnt, rate_d;
  logic              err_d;

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state == RAMP);

  // State register; reset aborts any ramp in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT_STATE;
      duty_out  <= INIT_DUTY;
      target    <= INIT_TARGET;
      err_range <= 1'b0;
      rate_cnt  <= '0;
    end else begin
      state     <= state_d;
      duty_out  <= duty_d;
      target    <= target_d;
      err_range <= err_d;
      rate_cnt  <= rate_d;
    end
  end

  // Next-state: accept new targets in IDLE, step duty on every RATE-th boundary in RAMP
  always_comb begin
    state_d  = state;
    duty_d   = duty_out;
    target_d = target;
    err_d    = err_range;
    rate_d   = rate_cnt;

    if (err_clr) err_d = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_duty > MAX_DUTY) begin
            target_d = MAX_DUTY;
            err_d    = 1'b1;
          end else begin
            target_d = req_duty;
          end
        end else if (inc_pulse && !dec_pulse) begin
          target_d = (target >= MAX_DUTY) ? MAX_DUTY : target + DUTY_W'(1);
        end else if (dec_pulse && !inc_pulse) begin
          target_d = (target == '0) ? target : target - DUTY_W'(1);
        end
        if (target_d != duty_out) begin
          state_d = RAMP;
          rate_d  = '0;
        end
      end
      RAMP: begin
        if (period_end) begin
          if (rate_cnt == RATE_LAST) begin
            rate_d = '0;
            duty_d = (duty_out < target) ? duty_out + DUTY_W'(1) : duty_out - DUTY_W'(1);
            if (duty_d == target) state_d = IDLE;
          end else begin
            rate_d = rate_cnt + RATE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench for pwm_duty_sequencer: expected output changes are queued by the stimulus and popped by a monitor.
module tb_pwm_duty_sequencer;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] duty;
    logic [W-1:0] tgt;
    logic         busy;
    logic         err;
  } rec_t;

  logic         clk, rst, period_end, req_valid, req_ready, inc_pulse, dec_pulse, err_clr;
  logic [W-1:0] req_duty, duty_out, target;
  logic         busy, err_range;

  int checks = 0;
  int errors = 0;
  rec_t exp_q[$];
  logic pe_en;

  pwm_duty_sequencer #(.STEPS(10), .DUTY_W(W), .DEFAULT_DUTY(5), .RATE(2)) dut (
    .clk(clk), .rst(rst), .period_end(period_end),
    .req_valid(req_valid), .req_duty(req_duty), .req_ready(req_ready),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .err_clr(err_clr),
    .duty_out(duty_out), .target(target), .busy(busy), .err_range(err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PWM counter model: period_end high during count 9 of every 10 clocks
  initial begin
    int cnt;
    cnt = 0;
    period_end = 1'b0;
    forever begin
      @(negedge clk);
      cnt = (cnt == 9) ? 0 : cnt + 1;
      period_end = pe_en && (cnt == 9);
    end
  end

  function automatic rec_t mk(input int d, input int t, input logic b, input logic e);
    mk = {W'(d), W'(t), b, e};
  endfunction

  task automatic push(input int d, input int t, input logic b, input logic e);
    exp_q.push_back(mk(d, t, b, e));
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_pe(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!period_end) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(busy), 0);
  endtask

  task automatic wait_duty(input int v);
    int n;
    n = 0;
    while (int'(duty_out) != v && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_duty", int'(duty_out), v);
  endtask

  task automatic push_softstart();
`ifdef PWM_SEQ_SOFTSTART_EN
    for (int d = 1; d < 5; d++) push(d, 5, 1'b1, 1'b0);
    push(5, 5, 1'b0, 1'b0);
`endif
  endtask

  // Monitor: any change of the observed outputs must match the next queued record
  initial begin
    rec_t cur, prev, exp_r;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {duty_out, target, busy, err_range};
      if (rst) begin
        prev = cur;
      end else if (cur != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got duty=%0d target=%0d busy=%0b err=%0b expected no change",
                   cur.duty, cur.tgt, cur.busy, cur.err);
        end else begin
          exp_r = exp_q.pop_front();
          if (cur !== exp_r) begin
            errors++;
            $display("FAIL sb_step: got duty=%0d target=%0d busy=%0b err=%0b expected duty=%0d target=%0d busy=%0b err=%0b",
                     cur.duty, cur.tgt, cur.busy, cur.err, exp_r.duty, exp_r.tgt, exp_r.busy, exp_r.err);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
`ifdef PWM_SEQ_SOFTSTART_EN
    localparam int RST_DUTY = 0;
    localparam int RST_BUSY = 1;
`else
    localparam int RST_DUTY = 5;
    localparam int RST_BUSY = 0;
`endif
    rst = 1'b1; pe_en = 1'b1;
    req_valid = 1'b0; req_duty = '0; inc_pulse = 1'b0; dec_pulse = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty", int'(duty_out), RST_DUTY);
    chk("rst_target", int'(target), 5);
    chk("rst_busy", int'(busy), RST_BUSY);
    chk("rst_err", int'(err_range), 0);
    chk("rst_ready", int'(req_ready), 0);
    push_softstart();
    rst = 1'b0;
    #1;
    chk("release_ready", int'(req_ready), 1 - RST_BUSY);
    @(negedge clk);
`ifdef PWM_SEQ_SOFTSTART_EN
    wait_pe(9);
    chk("soft_ready_low", int'(req_ready), 0);
    wait_pe(1);
    chk("soft_duty", int'(duty_out), 5);
    chk("soft_ready", int'(req_ready), 1);
`endif

    // Ramp 5 -> 8, one step every second period_end
    req_valid = 1'b1; req_duty = 4'd8;
    push(5, 8, 1'b1, 1'b0); push(6, 8, 1'b1, 1'b0); push(7, 8, 1'b1, 1'b0); push(8, 8, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t1_busy", int'(busy), 1);
    chk("t1_target", int'(target), 8);
    wait_pe(2); chk("t1_step6", int'(duty_out), 6);
    wait_pe(2); chk("t1_step7", int'(duty_out), 7);
    wait_pe(2); chk("t1_step8", int'(duty_out), 8);
    chk("t1_idle", int'(busy), 0);

    // Out-of-range request clamps to 10; err_clr during the ramp
    req_valid = 1'b1; req_duty = 4'd13;
    push(8, 10, 1'b1, 1'b1); push(8, 10, 1'b1, 1'b0); push(9, 10, 1'b1, 1'b0); push(10, 10, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t2_err", int'(err_range), 1);
    chk("t2_clamp", int'(target), 10);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t2_errclr", int'(err_range), 0);
    wait_idle("t2_timeout");

    // Saturation at the top, then ramp down to 0 and saturation at the bottom
    inc_pulse = 1'b1;
    @(negedge clk);
    inc_pulse = 1'b0;
    chk("t3_inc_sat", int'(target), 10);
    chk("t3_inc_busy", int'(busy), 0);
    req_valid = 1'b1; req_duty = 4'd0;
    push(10, 0, 1'b1, 1'b0);
    for (int d = 9; d >= 1; d--) push(d, 0, 1'b1, 1'b0);
    push(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle("t3_down_timeout");
    dec_pulse = 1'b1;
    @(negedge clk);
    dec_pulse = 1'b0;
    chk("t3_dec_sat", int'(target), 0);
    req_valid = 1'b1; req_duty = 4'd5;
    push(0, 5, 1'b1, 1'b0);
    for (int d = 1; d <= 4; d++) push(d, 5, 1'b1, 1'b0);
    push(5, 5, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle("t3_up_timeout");
    inc_pulse = 1'b1; dec_pulse = 1'b1;
    @(negedge clk);
    inc_pulse = 1'b0; dec_pulse = 1'b0;
    chk("t3_incdec", int'(target), 5);
    inc_pulse = 1'b1;
    push(5, 6, 1'b1, 1'b0); push(6, 6, 1'b0, 1'b0);
    @(negedge clk);
    inc_pulse = 1'b0;
    chk("t3_inc", int'(target), 6);
    wait_idle("t3_inc_timeout");
    dec_pulse = 1'b1;
    push(6, 5, 1'b1, 1'b0); push(5, 5, 1'b0, 1'b0);
    @(negedge clk);
    dec_pulse = 1'b0;
    wait_idle("t3_dec_timeout");

    // Ramp 5 -> 2 with a held request and an ignored inc_pulse
    req_valid = 1'b1; req_duty = 4'd2;
    push(5, 2, 1'b1, 1'b0); push(4, 2, 1'b1, 1'b0); push(3, 2, 1'b1, 1'b0); push(2, 2, 1'b0, 1'b0);
    for (int d = 2; d <= 7; d++) push(d, 9, 1'b1, 1'b0);
    @(negedge clk);
    req_duty = 4'd9;
    inc_pulse = 1'b1;
    chk("t4_ready_low", int'(req_ready), 0);
    @(negedge clk);
    inc_pulse = 1'b0;
    chk("t4_inc_ignored", int'(target), 2);
    wait_idle("t4_timeout");
    chk("t4_ready_high", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t4_held_accept", int'(target), 9);
    chk("t4_held_busy", int'(busy), 1);

    // Asynchronous reset in the middle of the 2 -> 9 ramp
    wait_duty(7);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_duty", int'(duty_out), RST_DUTY);
    chk("t5_async_target", int'(target), 5);
    chk("t5_async_busy", int'(busy), RST_BUSY);
    chk("t5_async_ready", int'(req_ready), 0);
    @(negedge clk);
    push_softstart();
    rst = 1'b0;
    @(negedge clk);
    wait_idle("t5_settle_timeout");
    chk("t5_duty", int'(duty_out), 5);
    repeat (30) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Duty-cycle controller that sequences the 10-step PWM generator. It accepts absolute duty targets over a valid/ready handshake, plus single-step increment/decrement pulses from the debounced buttons. It moves the generator's duty register toward the target one step at a time, only at PWM period boundaries, so the output never sees a mid-period duty change. It sits between the button/debounce logic and the PWM compare stage, and drives that stage's duty input.

## Interface
Parameters:
- STEPS, 10: PWM period length in clocks; legal duty range is 0..STEPS.
- DUTY_W, 4: width of duty and target values; must satisfy 2^DUTY_W > STEPS.
- DEFAULT_DUTY, 5: duty and target value after reset.
- RATE, 2: number of period boundaries between successive one-step duty changes while ramping; minimum 1.

Ports:
- clk, input, 1: single clock; all state is updated on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- period_end, input, 1: pulse from the PWM counter, high during the last clock of each period (counter == STEPS-1).
- req_valid, input, 1: an absolute target is offered.
- req_duty, input, DUTY_W: the offered target.
- req_ready, output, 1: the block accepts req_duty this cycle.
- inc_pulse, input, 1: one-cycle request for target+1.
- dec_pulse, input, 1: one-cycle request for target-1.
- err_clr, input, 1: clears err_range.
- duty_out, output, DUTY_W: registered duty value fed to the PWM compare.
- target, output, DUTY_W: current target value.
- busy, output, 1: high while duty_out != target.
- err_range, output, 1: sticky flag, set when an out-of-range request was clamped.

## Operation
- State machine has two states:
  - IDLE: duty_out == target.
  - RAMP: duty_out != target.
- req_ready = 1 only in IDLE and only when rst is low. A transfer occurs when req_valid && req_ready.
- Accepted request: target <= min(req_duty, STEPS). If req_duty > STEPS, err_range <= 1. Then go to RAMP if the new target != duty_out.
- inc_pulse/dec_pulse are honoured only in IDLE; they are ignored in RAMP.
  - inc saturates at STEPS; dec saturates at 0. Neither sets err_range.
- Priority within one cycle:
  - A handshake transfer beats inc/dec.
  - inc and dec together are both ignored.
- rate_cnt (counts 0..RATE-1) advances only on period_end while in RAMP. On the period_end where rate_cnt == RATE-1:
  - duty_out steps ±1 toward target;
  - rate_cnt returns to 0.
- rate_cnt clears to 0 on every entry into RAMP. The first step therefore lands on the RATE-th boundary after acceptance.
- When duty_out reaches target, return to IDLE.
- err_range holds until err_clr. If err_clr and a new clamp occur in the same cycle, set wins.
- busy = (state == RAMP), registered.

## Timing
- Reset values: duty_out = DEFAULT_DUTY, target = DEFAULT_DUTY, state IDLE, busy = 0, err_range = 0, rate_cnt = 0, req_ready = 0 while rst is high.
  - Under PWM_SEQ_SOFTSTART_EN, duty_out = 0 and state is RAMP instead.
- target and busy update on the edge that accepts the request, i.e. one clock of latency.
- duty_out changes only on an edge where period_end = 1. The new duty therefore governs the entire following period.
- A full ramp of distance d takes d*RATE period boundaries. Example: 5 to 8 with RATE = 2 completes on the 6th period_end.
- period_end has no effect in IDLE.
- An asserted rst mid-ramp aborts the ramp immediately (asynchronously); there is no partial step.
- duty_out never goes outside 0..STEPS and never jumps by more than 1 per step.

## Configuration
- PWM_SEQ_SOFTSTART_EN defined: after reset release, duty_out ramps from 0 up to DEFAULT_DUTY at the normal RATE. During this ramp busy = 1 and req_ready = 0.
- PWM_SEQ_SOFTSTART_EN undefined: duty_out = DEFAULT_DUTY immediately and the block starts in IDLE.

## Test plan
- Reset, macro off: duty_out = 5, target = 5, busy = 0, req_ready = 1 after release. Then req_duty = 8 accepted -> busy = 1; duty_out reaches 6, 7, 8 on the 2nd, 4th and 6th period_end; busy = 0 the following cycle.
- req_duty = 13 (out of range) -> target = 10, err_range = 1. Then err_clr -> err_range = 0, while the ramp continues unaffected.
- In IDLE at 10: inc_pulse -> target stays 10. At 0: dec_pulse -> target stays 0. inc and dec together at 5 -> no change.
- During a ramp from 5 to 2: req_valid held with req_ready = 0, inc_pulse ignored. The held request is accepted on the first cycle after busy falls.
- Assert rst mid-ramp at duty 7 (heading to 9) -> duty_out = 5 and state IDLE without waiting for a clock edge.
- Macro on: after reset, duty_out steps 0 through 5 across 10 period_end pulses. req_ready = 0 until duty_out = 5.
